// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter
//   Two-port round-robin arbiter in front of a command-driven SPI RAM.
//   A granted transaction becomes two RAM command words (address, then
//   data or read-data), after which a write completes immediately and a
//   read waits for the RAM's read-data valid.
//
//   Optional feature: define SPI_RAM_ARB_TIMEOUT_EN to abort a read that
//   sees no ram_tx_valid within 4 cycles of entering the wait state (err +
//   done with rdata = 0). Without it the read waits forever and err = 0.
//
// Ports
//   clk, rst_n      clock (rising edge), async active-low reset
//   req/we          per-port request and op (1 = write)
//   addr/wdata      per-port fields, port i at [i*ADDR_SIZE +: ADDR_SIZE]
//   gnt/done/err    per-port one-cycle pulses
//   rdata           read result, valid with done after a read
//   busy            arbiter is not idle
//   ram_din         command word {opcode[1:0], payload}
//   ram_rx_valid    command strobe
//   ram_dout        RAM read data
//   ram_tx_valid    RAM read data valid (level)
module spi_ram_arbiter #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req,
    input  logic [1:0]             we,
    input  logic [2*ADDR_SIZE-1:0] addr,
    input  logic [2*ADDR_SIZE-1:0] wdata,
    output logic [1:0]             gnt,
    output logic [1:0]             done,
    output logic [1:0]             err,
    output logic [ADDR_SIZE-1:0]   rdata,
    output logic                   busy,
    output logic [ADDR_SIZE+1:0]   ram_din,
    output logic                   ram_rx_valid,
    input  logic [ADDR_SIZE-1:0]   ram_dout,
    input  logic                   ram_tx_valid
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CMD_ADDR = 2'd1,
        CMD_DATA = 2'd2,
        RD_WAIT  = 2'd3
    } state_t;

    state_t                 state, state_nxt;
    logic                   last, last_nxt;       // port served most recently
    logic                   owner, owner_nxt;     // port of the transaction in flight
    logic                   op_we, op_we_nxt;
    logic [ADDR_SIZE-1:0]   op_addr, op_addr_nxt;
    logic [ADDR_SIZE-1:0]   op_wdata, op_wdata_nxt;
    // A write finishes when CMD_DATA is sent; its done pulse is emitted one
    // cycle later, from IDLE, so a new grant can overlap it.
    logic                   wr_pend, wr_pend_nxt;

    logic [1:0]             gnt_nxt, done_nxt;
    logic [ADDR_SIZE-1:0]   rdata_nxt;
    logic [ADDR_SIZE+1:0]   din_nxt;
    logic                   rxv_nxt;
    logic                   win;

`ifdef SPI_RAM_ARB_TIMEOUT_EN
    logic [2:0]             cnt, cnt_nxt;
    logic [1:0]             err_nxt;
`endif

    // Round-robin: on a tie the port not served last wins.
    always_comb begin
        if (req == 2'b11) win = ~last;
        else              win = req[1];
    end

    always_comb begin
        state_nxt    = state;
        last_nxt     = last;
        owner_nxt    = owner;
        op_we_nxt    = op_we;
        op_addr_nxt  = op_addr;
        op_wdata_nxt = op_wdata;
        wr_pend_nxt  = 1'b0;
        gnt_nxt      = 2'b00;
        done_nxt     = 2'b00;
        rdata_nxt    = rdata;
        din_nxt      = '0;
        rxv_nxt      = 1'b0;
`ifdef SPI_RAM_ARB_TIMEOUT_EN
        cnt_nxt      = 3'd0;
        err_nxt      = 2'b00;
`endif
        unique case (state)
            IDLE: begin
                if (wr_pend) done_nxt[owner] = 1'b1;
                if (req != 2'b00) begin
                    gnt_nxt[win] = 1'b1;
                    owner_nxt    = win;
                    last_nxt     = win;
                    op_we_nxt    = we[win];
                    op_addr_nxt  = addr[win*ADDR_SIZE +: ADDR_SIZE];
                    op_wdata_nxt = wdata[win*ADDR_SIZE +: ADDR_SIZE];
                    state_nxt    = CMD_ADDR;
                end
            end
            CMD_ADDR: begin
                rxv_nxt   = 1'b1;
                din_nxt   = {(op_we ? 2'b00 : 2'b10), op_addr};
                state_nxt = CMD_DATA;
            end
            CMD_DATA: begin
                rxv_nxt = 1'b1;
                if (op_we) begin
                    din_nxt     = {2'b01, op_wdata};
                    wr_pend_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    din_nxt   = {2'b11, {ADDR_SIZE{1'b0}}};
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (ram_tx_valid) begin
                    rdata_nxt       = ram_dout;
                    done_nxt[owner] = 1'b1;
                    state_nxt       = IDLE;
                end
`ifdef SPI_RAM_ARB_TIMEOUT_EN
                // cnt counts wait cycles already spent; the 4th silent one aborts.
                else if (cnt == 3'd3) begin
                    rdata_nxt       = '0;
                    done_nxt[owner] = 1'b1;
                    err_nxt[owner]  = 1'b1;
                    state_nxt       = IDLE;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last         <= 1'b1;
            owner        <= 1'b0;
            op_we        <= 1'b0;
            op_addr      <= '0;
            op_wdata     <= '0;
            wr_pend      <= 1'b0;
            gnt          <= 2'b00;
            done         <= 2'b00;
            rdata        <= '0;
            busy         <= 1'b0;
            ram_din      <= '0;
            ram_rx_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            last         <= last_nxt;
            owner        <= owner_nxt;
            op_we        <= op_we_nxt;
            op_addr      <= op_addr_nxt;
            op_wdata     <= op_wdata_nxt;
            wr_pend      <= wr_pend_nxt;
            gnt          <= gnt_nxt;
            done         <= done_nxt;
            rdata        <= rdata_nxt;
            busy         <= (state_nxt != IDLE);
            ram_din      <= din_nxt;
            ram_rx_valid <= rxv_nxt;
        end
    end

`ifdef SPI_RAM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 3'd0;
            err <= 2'b00;
        end else begin
            cnt <= cnt_nxt;
            err <= err_nxt;
        end
    end
`else
    assign err = 2'b00;
`endif

endmodule

// File: tb/tb_spi_ram_arbiter.sv
module tb_spi_ram_arbiter;
    localparam int AW  = 8;
    localparam int BIG = 32'h7fff_ffff;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req, we;
    logic [2*AW-1:0] addr, wdata;
    logic [1:0]      gnt, done, err;
    logic [AW-1:0]   rdata;
    logic            busy;
    logic [AW+1:0]   ram_din;
    logic            ram_rx_valid;
    logic [AW-1:0]   ram_dout;
    logic            ram_tx_valid;

    spi_ram_arbiter #(.ADDR_SIZE(AW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0, miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- RAM model (external device) ----------------
    logic [AW-1:0] ram_mem [256];
    logic [AW-1:0] ram_ptr;
    bit            mute = 0;   // RAM never answers read-data commands
    initial begin
        for (int i = 0; i < 256; i++) ram_mem[i] = '0;
        ram_tx_valid = 1'b0;
        ram_dout     = '0;
        ram_ptr      = '0;
    end
    always @(posedge clk) begin
        if (ram_rx_valid) begin
            case (ram_din[AW+1:AW])
                2'b00, 2'b10: begin ram_ptr <= ram_din[AW-1:0]; ram_tx_valid <= 1'b0; end
                2'b01: begin ram_mem[ram_ptr] <= ram_din[AW-1:0]; ram_tx_valid <= 1'b0; end
                default: if (!mute) begin ram_dout <= ram_mem[ram_ptr]; ram_tx_valid <= 1'b1; end
            endcase
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct { int cyc; logic [AW+1:0] din; } cmd_t;
    typedef struct { int cyc; int port; bit rd; logic [AW-1:0] rdata; bit er; } dn_t;
    cmd_t cmd_q[$];
    dn_t  done_q[$];
    logic [AW-1:0] model_mem [256];
    initial for (int i = 0; i < 256; i++) model_mem[i] = '0;

    bit   chk_en = 0;
    int   next_ok = 0;       // first cycle in which a new grant may appear
    int   model_last = 1;
    logic [1:0]      req_prev = 2'b00, we_prev = 2'b00;
    logic [2*AW-1:0] addr_prev = '0, wdata_prev = '0;

    always @(negedge clk) begin
        logic [1:0] exp_g;
        int w;
        logic [AW-1:0] a, d;
        if (chk_en) begin
            exp_g = 2'b00;
            if (cyc >= next_ok && req_prev != 2'b00) begin
                if (req_prev == 2'b11) w = 1 - model_last;
                else                   w = req_prev[1] ? 1 : 0;
                exp_g[w] = 1'b1;
            end
            check("gnt", 32'(gnt), 32'(exp_g));
            if (exp_g != 2'b00) begin
                a = addr_prev[w*AW +: AW];
                d = wdata_prev[w*AW +: AW];
                model_last = w;
                if (we_prev[w]) begin
                    model_mem[a] = d;
                    cmd_q.push_back('{cyc+1, {2'b00, a}});
                    cmd_q.push_back('{cyc+2, {2'b01, d}});
                    done_q.push_back('{cyc+3, w, 1'b0, '0, 1'b0});
                    next_ok = cyc + 3;
                end else begin
                    cmd_q.push_back('{cyc+1, {2'b10, a}});
                    cmd_q.push_back('{cyc+2, {2'b11, {AW{1'b0}}}});
                    if (!mute) begin
                        done_q.push_back('{cyc+4, w, 1'b1, model_mem[a], 1'b0});
                        next_ok = cyc + 5;
                    end else begin
`ifdef SPI_RAM_ARB_TIMEOUT_EN
                        done_q.push_back('{cyc+6, w, 1'b1, '0, 1'b1});
                        next_ok = cyc + 7;
`else
                        next_ok = BIG;
`endif
                    end
                end
            end
            // command bus
            if (cmd_q.size() > 0 && cmd_q[0].cyc == cyc) begin
                check("ram_rx_valid", 32'(ram_rx_valid), 32'd1);
                check("ram_din", 32'(ram_din), 32'(cmd_q[0].din));
                void'(cmd_q.pop_front());
            end else begin
                check("ram_idle", 32'({ram_rx_valid, ram_din}), 32'd0);
            end
            // completions
            if (done != 2'b00 || err != 2'b00) begin
                if (done_q.size() == 0) begin
                    check("spurious_done", 32'({err, done}), 32'd0);
                end else begin
                    check("done_cycle", 32'(cyc), 32'(done_q[0].cyc));
                    check("done_port", 32'(done), 32'(2'b01 << done_q[0].port));
                    check("err", 32'(err), done_q[0].er ? 32'(2'b01 << done_q[0].port) : 32'd0);
                    if (done_q[0].rd) check("rdata", 32'(rdata), 32'(done_q[0].rdata));
                    void'(done_q.pop_front());
                end
            end else if (done_q.size() > 0 && done_q[0].cyc < cyc) begin
                check("missing_done", 32'(done), 32'(2'b01 << done_q[0].port));
                void'(done_q.pop_front());
            end
        end
        req_prev   = req;
        we_prev    = we;
        addr_prev  = addr;
        wdata_prev = wdata;
    end

    // ---------------- stimulus ----------------
    task automatic rand_fields(input int p);
        we[p]            = 1'($urandom_range(0, 1));
        addr[p*AW +: AW] = AW'($urandom_range(0, 15));
        wdata[p*AW +: AW] = AW'($urandom);
    endtask

    task automatic do_txn(input int p, input logic w, input logic [AW-1:0] a, input logic [AW-1:0] d);
        bit ok = 0;
        @(posedge clk); #1;
        we[p] = w; addr[p*AW +: AW] = a; wdata[p*AW +: AW] = d; req[p] = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk); #1;
            if (gnt[p]) begin req[p] = 1'b0; ok = 1; end
        end
        if (!ok) begin check("gnt_timeout", 32'd0, 32'd1); req[p] = 1'b0; end
    endtask

    // mode 0: random sparse requests; mode 1: both ports request continuously
    task automatic run(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (gnt[p]) begin
                    if (mode == 1) rand_fields(p);
                    else           req[p] = 1'b0;
                end else if (!req[p] && (mode == 1 || $urandom_range(0, 3) == 0)) begin
                    rand_fields(p);
                    req[p] = 1'b1;
                end
            end
        end
    endtask

    task automatic settle(input bit chk_first);
        bit first = chk_first;
        for (int i = 0; i < 100 && req != 2'b00; i++) begin
            @(posedge clk); #1;
            if (first && gnt != 2'b00) begin
                check("tie_after_reset", 32'(gnt), 32'd1);
                first = 0;
            end
            req = req & ~gnt;
        end
        if (req != 2'b00) begin check("settle_timeout", 32'(req), 32'd0); req = 2'b00; end
    endtask

    task automatic drain;
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk); #1;
            ok = (done_q.size() == 0 && cmd_q.size() == 0 && !busy);
        end
        if (!ok) check("drain_timeout", 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},  32'(gnt), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"},  32'(err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rdata"}, 32'(rdata), 32'd0);
        check({tag, "_ram"},  32'({ram_rx_valid, ram_din}), 32'd0);
    endtask

    task automatic do_reset;
        chk_en = 0;
        rst_n  = 1'b0;
        #1;
        check_all_zero("reset");
        cmd_q.delete();
        done_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        next_ok    = 0;
        model_last = 1;
        chk_en     = 1;
    endtask

    initial begin
        logic [AW-1:0] old;
        req = 2'b00; we = 2'b00; addr = '0; wdata = '0;
        rst_n = 1'b0;
        #2;
        check_all_zero("por");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1;

        // directed write then read-back of the same address
        do_txn(0, 1'b1, 8'h12, 8'hA5);
        drain();
        do_txn(1, 1'b0, 8'h12, 8'h00);
        drain();

        // both ports requesting back to back
        run(40, 1);
        settle(0);
        drain();

        // random traffic
        run(600, 0);
        settle(0);
        drain();

        // read the RAM never answers
        mute = 1;
        do_txn(1, 1'b0, 8'h05, 8'h00);
`ifdef SPI_RAM_ARB_TIMEOUT_EN
        drain();
        mute = 0;
`else
        repeat (20) begin
            @(posedge clk); #1;
            check("busy_stuck", 32'(busy), 32'd1);
        end
        mute = 0;
        @(posedge clk); #1;
        do_reset();
`endif

        // reset in the middle of a write's CMD_DATA cycle
        old = model_mem[8'h34];
        do_txn(0, 1'b1, 8'h34, 8'h5A);
        @(posedge clk); #1;
        do_reset();
        model_mem[8'h34] = old;
        @(posedge clk); #1;
        rand_fields(0); rand_fields(1);
        req = 2'b11;
        settle(1);
        drain();

        // confirm the dropped write never reached the RAM
        do_txn(1, 1'b0, 8'h34, 8'h00);
        drain();

        run(200, 0);
        settle(0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout @cyc %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
